// File: rtl/delta_event_packer.sv
// delta_event_packer: timestamps delta-LIF spikes, queues them and streams each event as a ts byte then a diff byte
module delta_event_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spike_in,
    input  logic [7:0]               diff_in,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, SEND_TS, SEND_DIFF} state_t;
    state_t state, state_nxt;
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] ts;
    logic full, pop, push, drop;
    assign full = fifo_count == (AW+1)'(DEPTH);
    assign pop = state == SEND_DIFF && out_ready;
    assign push = spike_in && (!full || pop);
    assign drop = spike_in && full && !pop;
    assign out_valid = state != IDLE;
    assign out_last = state == SEND_DIFF;
    assign out_data = state == SEND_TS ? mem[rd_ptr][15:8] : state == SEND_DIFF ? mem[rd_ptr][7:0] : 8'd0;
    // event storage; a slot is only read once the matching count says it was written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ts, diff_in};
    end
    // timestamp, queue pointers/occupancy and drop bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= 8'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            ts <= ts + 8'd1;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_count <= push && !pop ? fifo_count + (AW+1)'(1) : !push && pop ? fifo_count - (AW+1)'(1) : fifo_count;
            overflow <= overflow | drop;
            drop_cnt <= drop && drop_cnt != 8'hFF ? drop_cnt + 8'd1 : drop_cnt;
        end
    end
    // output state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end
    // packet sequencing: ts byte, then diff byte, pop on the diff handshake
    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == SEND_TS ? (out_ready ? SEND_DIFF : SEND_TS) :
                    state == SEND_DIFF ? (out_ready ? (fifo_count > (AW+1)'(1) ? SEND_TS : IDLE) : SEND_DIFF) :
                    (fifo_count != '0 ? SEND_TS : IDLE);
    end
endmodule

// File: tb/tb_delta_event_packer.sv
// tb_delta_event_packer: vector table, corner sequences and random traffic against a queue-based event model
module tb_delta_event_packer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset, spike_in, out_valid, out_last, out_ready, overflow;
    logic [7:0] diff_in, out_data, drop_cnt;
    logic [$clog2(DEPTH):0] fifo_count;
    int checks = 0;
    int failures = 0;
    logic [15:0] mq[$];
    int midx;
    logic [7:0] mts, mdrop;
    logic movf;
    logic [7:0] seen_ts[$];

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       r;
        int         cnt;
        logic       v;
        logic [7:0] data;
        logic       last;
    } vec_t;
    vec_t tbl[10];

    delta_event_packer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .diff_in(diff_in),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock cycle: update the model from this cycle's inputs, advance the DUT, compare
    task automatic step(input logic s, input logic [7:0] d, input logic r);
        logic hs, pop, pv, pl;
        logic [7:0] eb, pd;
        spike_in = s;
        diff_in = d;
        out_ready = r;
        hs = out_valid && r;
        pv = out_valid && !r;
        pd = out_data;
        pl = out_last;
        pop = 1'b0;
        if (hs) begin
            checks++;
            if (mq.size() == 0) begin
                failures++;
                $display("FAIL byte_without_event: got %0h expected no byte", out_data);
            end else begin
                eb = midx == 0 ? mq[0][15:8] : mq[0][7:0];
                chk("out_data", out_data, eb);
                chk("out_last", out_last, midx);
                if (midx == 0) seen_ts.push_back(out_data);
                pop = midx == 1;
                midx = midx ^ 1;
            end
        end
        if (s) begin
            if (mq.size() < DEPTH || pop) mq.push_back({mts, d});
            else begin
                movf = 1'b1;
                mdrop = mdrop == 8'hFF ? 8'hFF : mdrop + 8'd1;
            end
        end
        if (pop) void'(mq.pop_front());
        mts++;
        @(posedge clk);
        #1;
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, movf);
        chk("drop_cnt", drop_cnt, mdrop);
        if (mq.size() == 0) chk("idle_valid", out_valid, 0);
        if (pv) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, pd);
            chk("hold_last", out_last, pl);
        end
    endtask

    // reset with a spike and ready present, which must both be ignored
    task automatic do_reset();
        reset = 1'b1;
        spike_in = 1'b1;
        diff_in = 8'hAA;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        seen_ts.delete();
        midx = 0;
        mts = 8'd0;
        mdrop = 8'd0;
        movf = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || out_valid) && n < 60) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d events left expected 0", mq.size());
        end
    endtask

    initial begin
        logic [7:0] hold;
        tbl[0] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h99, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h37, 1'b1, 1, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h05, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h37, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        reset = 1'b1;
        spike_in = 1'b0;
        diff_in = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].s, tbl[i].d, tbl[i].r);
            chk("tbl_count", fifo_count, tbl[i].cnt);
            chk("tbl_valid", out_valid, tbl[i].v);
            chk("tbl_data", out_data, tbl[i].data);
            chk("tbl_last", out_last, tbl[i].last);
        end
        do_reset();
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        hold = out_data;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, hold);
        end
        drain();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        drain();
        chk("ovf_drained", seen_ts.size(), 4);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("fullpop_last", out_last, 1);
        step(1'b1, 8'h77, 1'b1);
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_ovf", overflow, 0);
        drain();
        do_reset();
        while (mts != 8'hFF) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        drain();
        chk("wrap_n", seen_ts.size(), 2);
        if (seen_ts.size() == 2) begin
            chk("wrap_ts0", seen_ts[0], 8'hFF);
            chk("wrap_ts1", seen_ts[1], 8'h01);
        end
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("mid_in_diff", out_last, 1);
        do_reset();
        step(1'b1, 8'h11, 1'b1);
        drain();
        chk("mid_ts_n", seen_ts.size(), 1);
        if (seen_ts.size() == 1) chk("mid_ts0", seen_ts[0], 8'h00);
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b0);
        chk("sat_drop", drop_cnt, 255);
        drain();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 60);
            if (i % 500 == 499) drain();
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
